nbank_tile_buffer: RTL and testbench
====================================

NBANK_TILE_BUFFER -- requirements
Module: nbank_tile_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 128, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, per-bank word address width.
REQ-003 SHALL have parameter DEPTH, default 1024, words per bank; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter NUM_BANKS, default 4, bank count, legal range 2..8.
REQ-005 SHALL derive local constant BANK_W = max(1, clog2(NUM_BANKS)).
REQ-006 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  in  1  write strobe into the producer-owned bank.
REQ-009 SHALL have port wr_addr  in  ADDR_W  write word address.
REQ-010 SHALL have port wr_data  in  DATA_W  write word.
REQ-011 SHALL have port wr_commit  in  1  producer finished the current bank and hands it to the consumer.
REQ-012 SHALL have port wr_ready  out  1  producer currently owns a free bank.
REQ-013 SHALL have port wr_bank  out  BANK_W  index of the producer-owned bank.
REQ-014 SHALL have port rd_en  in  1  read strobe from the consumer-owned bank.
REQ-015 SHALL have port rd_addr  in  ADDR_W  read word address.
REQ-016 SHALL have port rd_data  out  DATA_W  registered read word.
REQ-017 SHALL have port rd_valid  out  1  rd_data holds the result of an accepted read.
REQ-018 SHALL have port rd_release  in  1  consumer finished the current bank and returns it to the free pool.
REQ-019 SHALL have port rd_ready  out  1  consumer currently owns a full bank.
REQ-020 SHALL have port rd_bank  out  BANK_W  index of the consumer-owned bank.
REQ-021 SHALL have port full_count  out  BANK_W+1  number of committed, unreleased banks.
REQ-022 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-023 SHALL manage banks as a ring: write pointer wp, read pointer rp, full count fc; wr_bank=wp, rd_bank=rp, full_count=fc.
REQ-024 SHALL drive wr_ready = (fc < NUM_BANKS) and rd_ready = (fc > 0), combinationally from registered state.
REQ-025 SHALL write wr_data to bank wp at wr_addr on wr_en when wr_ready=1; no effect on other banks.
REQ-026 SHALL accept wr_commit only when wr_ready=1: wp <= (wp+1) mod NUM_BANKS, fc +1; wrap from NUM_BANKS-1 to 0, including non-power-of-2 counts.
REQ-027 SHALL accept rd_release only when rd_ready=1: rp <= (rp+1) mod NUM_BANKS, fc -1.
REQ-028 SHALL, on simultaneous accepted commit and release, advance both pointers and leave fc unchanged.
REQ-029 SHALL apply wr_en and wr_commit in the same cycle to the pre-commit bank (write lands, then handoff).
REQ-030 SHALL accept rd_en only when rd_ready=1; rd_data <= bank rp [rd_addr] and rd_valid=1 on the next cycle (latency 1).
REQ-031 SHALL read the pre-release bank when rd_en and rd_release coincide.
REQ-032 SHALL deassert rd_valid the cycle after any cycle without an accepted read; rd_data holds its last value.
REQ-033 SHALL return the old stored word when reading an address of the consumer bank; producer and consumer never share a bank, so no read-during-write hazard exists.
REQ-034 SHALL ignore wr_en/wr_commit when wr_ready=0 and rd_en/rd_release when rd_ready=0, setting err=1 in each case; err clears only on reset.

Reset
REQ-035 SHALL, while rst=1, set wp=0, rp=0, fc=0, rd_valid=0, rd_data=0, err=0; wr_ready=1, rd_ready=0 afterwards.
REQ-036 SHALL, on reset mid-operation, discard all bank ownership (all banks free); RAM contents are not cleared.

Structure
REQ-037 SHALL place parameter defaults and the NUM_BANKS legal-range constants in the shared memory package.
REQ-038 SHALL instantiate NUM_BANKS copies of one sub-module, sdp_bram_bank (simple dual-port, registered read, block RAM inference).

Verification
REQ-039 SHALL cover: reset, NUM_BANKS=4 -> wr_ready=1, rd_ready=0, full_count=0, err=0.
REQ-040 SHALL cover: write 0xA0+i to addr i of bank 0, commit, read addr 0..3 -> rd_data 0xA0..0xA3, rd_valid 1 cycle after each rd_en.
REQ-041 SHALL cover: 4 commits without release -> full_count=4, wr_ready=0; 5th commit -> ignored, err=1, wp stays 0.
REQ-042 SHALL cover: NUM_BANKS=3, 7 commit/release pairs -> wr_bank sequence 1,2,0,1,2,0,1, no err.
REQ-043 SHALL cover: fc=2, simultaneous commit+release, rd_en at addr 5 same cycle -> fc stays 2, data from old rp bank.
REQ-044 SHALL cover: rst asserted with fc=3 -> next cycle fc=0, rd_valid=0, wr_bank=0, rd_bank=0.

Source files
------------

// File: rtl/nbank_tile_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nbank_tile_buffer_pkg
// Purpose  : Shared defaults, legal bank-count range and helpers for the
//            N-bank tile buffer.
// Revision : 1.0
// ============================================================================
package nbank_tile_buffer_pkg;

    localparam int c_DEF_DATA_W    = 128;
    localparam int c_DEF_ADDR_W    = 10;
    localparam int c_DEF_DEPTH     = 1024;
    localparam int c_DEF_NUM_BANKS = 4;

    localparam int c_NUM_BANKS_MIN = 2;
    localparam int c_NUM_BANKS_MAX = 8;

    // Bank index width; a two-bank ring still needs one bit.
    function automatic int bank_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nbank_tile_buffer_bank.sv
`default_nettype none
// ============================================================================
// Module   : sdp_bram_bank
// Purpose  : Simple dual-port RAM bank, one write port, one registered read.
// Revision : 1.0
// ============================================================================
module sdp_bram_bank #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Addresses past DEPTH are dropped rather than aliased.
    assign w_wr_ok = i_we && ({1'b0, i_waddr} < c_DEPTH);
    assign w_rd_ok = i_re && ({1'b0, i_raddr} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (w_rd_ok) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/nbank_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module   : nbank_tile_buffer
// Purpose  : Ring of NUM_BANKS RAM banks handed from a producer to a consumer.
// Revision : 1.0
// ============================================================================
module nbank_tile_buffer
    import nbank_tile_buffer_pkg::*;
#(
    parameter  int DATA_W    = c_DEF_DATA_W,
    parameter  int ADDR_W    = c_DEF_ADDR_W,
    parameter  int DEPTH     = c_DEF_DEPTH,
    parameter  int NUM_BANKS = c_DEF_NUM_BANKS,
    localparam int BANK_W    = bank_idx_w(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    output logic [BANK_W-1:0] wr_bank,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_release,
    output logic              rd_ready,
    output logic [BANK_W-1:0] rd_bank,
    output logic [BANK_W:0]   full_count,
    output logic              err
);

    if (NUM_BANKS < c_NUM_BANKS_MIN || NUM_BANKS > c_NUM_BANKS_MAX) begin : g_bad_num_banks
        $error("nbank_tile_buffer: NUM_BANKS out of range");
    end

    localparam logic [BANK_W:0]   c_NB   = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [BANK_W-1:0] c_LAST = BANK_W'(NUM_BANKS - 1);

    logic [BANK_W-1:0] r_wp;
    logic [BANK_W-1:0] r_rp;
    logic [BANK_W:0]   r_fc;
    logic              r_err;
    logic              r_rd_valid;
    logic              r_rd_has;
    logic [BANK_W-1:0] r_rd_sel;

    logic              w_wr_ready;
    logic              w_rd_ready;
    logic              w_wr_acc;
    logic              w_cm_acc;
    logic              w_rd_acc;
    logic              w_rl_acc;
    logic              w_viol;
    logic [DATA_W-1:0] w_bank_q [NUM_BANKS];
    logic [DATA_W-1:0] w_rd_data;

    // Modulo increment that also wraps correctly for non-power-of-2 rings.
    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_wr_ready = (r_fc < c_NB);
    assign w_rd_ready = (r_fc != '0);
    assign w_wr_acc   = wr_en      && w_wr_ready;
    assign w_cm_acc   = wr_commit  && w_wr_ready;
    assign w_rd_acc   = rd_en      && w_rd_ready;
    assign w_rl_acc   = rd_release && w_rd_ready;
    assign w_viol     = (!w_wr_ready && (wr_en || wr_commit)) ||
                        (!w_rd_ready && (rd_en || rd_release));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fc       <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_has   <= 1'b0;
            r_rd_sel   <= '0;
        end else begin
            if (w_cm_acc) begin
                r_wp <= ptr_inc(r_wp);
            end
            if (w_rl_acc) begin
                r_rp <= ptr_inc(r_rp);
            end
            if (w_cm_acc && !w_rl_acc) begin
                r_fc <= r_fc + 1'b1;
            end else if (w_rl_acc && !w_cm_acc) begin
                r_fc <= r_fc - 1'b1;
            end
            if (w_viol) begin
                r_err <= 1'b1;
            end
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_has <= 1'b1;
                r_rd_sel <= r_rp;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sdp_bram_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_wr_acc && (r_wp == BANK_W'(b))),
            .i_waddr (wr_addr),
            .i_wdata (wr_data),
            .i_re    (w_rd_acc && (r_rp == BANK_W'(b))),
            .i_raddr (rd_addr),
            .o_rdata (w_bank_q[b])
        );
    end

    // The last-read bank keeps its output register until it is read again,
    // which also moves r_rd_sel, so rd_data holds without an extra register.
    always_comb begin
        w_rd_data = '0;
        if (r_rd_has) begin
            w_rd_data = w_bank_q[r_rd_sel];
        end
    end

    assign wr_ready   = w_wr_ready;
    assign rd_ready   = w_rd_ready;
    assign wr_bank    = r_wp;
    assign rd_bank    = r_rp;
    assign full_count = r_fc;
    assign err        = r_err;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_nbank_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbank_tile_buffer
// Purpose  : Directed scoreboard bench for nbank_tile_buffer (4- and 3-bank).
// Revision : 1.0
// ============================================================================
module tb_nbank_tile_buffer;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];

    // ---- 4-bank instance ----
    logic          a_rst = 1'b1, a_wr_en = 1'b0, a_wr_commit = 1'b0;
    logic          a_rd_en = 1'b0, a_rd_release = 1'b0;
    logic [9:0]    a_wr_addr = '0, a_rd_addr = '0;
    logic [DW-1:0] a_wr_data = '0;
    logic          a_wr_ready, a_rd_valid, a_rd_ready, a_err;
    logic [1:0]    a_wr_bank, a_rd_bank;
    logic [2:0]    a_full_count;
    logic [DW-1:0] a_rd_data;

    nbank_tile_buffer #(.DATA_W(DW), .ADDR_W(10), .DEPTH(1024), .NUM_BANKS(4)) dut4 (
        .clk(clk), .rst(a_rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_commit(a_wr_commit),
        .wr_ready(a_wr_ready), .wr_bank(a_wr_bank),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .rd_release(a_rd_release), .rd_ready(a_rd_ready), .rd_bank(a_rd_bank),
        .full_count(a_full_count), .err(a_err)
    );

    // ---- 3-bank instance ----
    logic          b_rst = 1'b1, b_wr_en = 1'b0, b_wr_commit = 1'b0;
    logic          b_rd_en = 1'b0, b_rd_release = 1'b0;
    logic [3:0]    b_wr_addr = '0, b_rd_addr = '0;
    logic [DW-1:0] b_wr_data = '0;
    logic          b_wr_ready, b_rd_valid, b_rd_ready, b_err;
    logic [1:0]    b_wr_bank, b_rd_bank;
    logic [2:0]    b_full_count;
    logic [DW-1:0] b_rd_data;

    nbank_tile_buffer #(.DATA_W(DW), .ADDR_W(4), .DEPTH(16), .NUM_BANKS(3)) dut3 (
        .clk(clk), .rst(b_rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_commit(b_wr_commit),
        .wr_ready(b_wr_ready), .wr_bank(b_wr_bank),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .rd_release(b_rd_release), .rd_ready(b_rd_ready), .rd_bank(b_rd_bank),
        .full_count(b_full_count), .err(b_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read monitor: every valid beat must match the oldest expected read and
    // appear exactly one cycle after its request.
    always @(negedge clk) begin
        if (a_rd_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h expected no read", a_rd_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (a_rd_data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rd_data: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                             a_rd_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic a_read(input logic [9:0] addr, input logic [DW-1:0] exp);
        exp_t e;
        e.data = exp;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        a_rd_en   = 1'b1;
        a_rd_addr = addr;
    endtask

    task automatic a_write(input logic [9:0] addr, input logic [DW-1:0] data);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
    endtask

    task automatic a_idle();
        a_wr_en = 1'b0; a_wr_commit = 1'b0; a_rd_en = 1'b0; a_rd_release = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        chk("rst_wr_ready", a_wr_ready, 1);
        chk("rst_rd_ready", a_rd_ready, 0);
        chk("rst_full_count", a_full_count, 0);
        chk("rst_err", a_err, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_data", a_rd_data, 0);

        // Fill bank 0; last write coincides with the commit
        for (int i = 0; i < 4; i++) begin
            a_write(10'(i), DW'(32'hA0 + i));
            if (i == 3) a_wr_commit = 1'b1;
            tick();
            a_idle();
        end
        chk("commit0_fc", a_full_count, 1);
        chk("commit0_wr_bank", a_wr_bank, 1);
        chk("commit0_rd_ready", a_rd_ready, 1);

        for (int i = 0; i < 4; i++) begin
            a_read(10'(i), DW'(32'hA0 + i));
            tick();
            a_idle();
        end
        tick();
        chk("idle_rd_valid", a_rd_valid, 0);
        chk("idle_rd_hold", a_rd_data, 32'hA3);

        // Banks 1..3 get a marker at addr 5, then fill the ring
        for (int b = 1; b < 4; b++) begin
            a_write(10'd5, DW'(32'hA5 + 32'h10 * b));
            a_wr_commit = 1'b1;
            tick();
            a_idle();
        end
        chk("full_fc", a_full_count, 4);
        chk("full_wr_ready", a_wr_ready, 0);
        chk("full_wr_bank", a_wr_bank, 0);
        chk("full_err_clear", a_err, 0);
        a_wr_commit = 1'b1;
        tick();
        a_idle();
        chk("over_err", a_err, 1);
        chk("over_wr_bank", a_wr_bank, 0);
        chk("over_fc", a_full_count, 4);

        // Drain two banks to reach fc=2, rp=2
        a_rd_release = 1'b1; tick(); a_idle();
        a_rd_release = 1'b1; tick(); a_idle();
        chk("drain_fc", a_full_count, 2);
        chk("drain_rd_bank", a_rd_bank, 2);

        // Commit + release + read together: read sees the pre-release bank 2
        a_wr_commit = 1'b1; a_rd_release = 1'b1;
        a_read(10'd5, 32'hC5);
        tick();
        a_idle();
        chk("swap_fc", a_full_count, 2);
        chk("swap_rd_bank", a_rd_bank, 3);
        chk("swap_wr_bank", a_wr_bank, 1);

        // Producer writes the same address while consumer reads bank 3; commit -> fc=3
        a_write(10'd5, 32'hEE);
        a_wr_commit = 1'b1;
        a_read(10'd5, 32'hD5);
        tick();
        a_idle();
        chk("pre_rst_fc", a_full_count, 3);

        // Mid-operation reset with a read result in flight
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("mid_rst_fc", a_full_count, 0);
        chk("mid_rst_rd_valid", a_rd_valid, 0);
        chk("mid_rst_wr_bank", a_wr_bank, 0);
        chk("mid_rst_rd_bank", a_rd_bank, 0);
        chk("mid_rst_rd_data", a_rd_data, 0);
        chk("mid_rst_err", a_err, 0);

        // RAM contents survive reset
        a_wr_commit = 1'b1; tick(); a_idle();
        a_read(10'd2, 32'hA2); tick(); a_idle();
        a_rd_release = 1'b1; tick(); a_idle();
        chk("post_rst_fc", a_full_count, 0);

        // Read while empty is ignored and flagged
        a_rd_en = 1'b1; a_rd_addr = 10'd0;
        tick();
        a_idle();
        chk("empty_rd_err", a_err, 1);
        chk("empty_rd_valid", a_rd_valid, 0);

        // Three-bank ring: commit/release pairs must wrap 1,2,0,...
        for (int k = 1; k <= 7; k++) begin
            b_wr_commit = 1'b1; tick(); b_wr_commit = 1'b0;
            chk($sformatf("nb3_wr_bank_%0d", k), b_wr_bank, k % 3);
            b_rd_release = 1'b1; tick(); b_rd_release = 1'b0;
            chk($sformatf("nb3_rd_bank_%0d", k), b_rd_bank, k % 3);
        end
        chk("nb3_err", b_err, 0);
        chk("nb3_fc", b_full_count, 0);

        tick(); tick();
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
